// File: rtl/or1k_branch_resolve_unit_if.sv
// Interface between the decode/execute pipeline, the branch resolve unit and the BHT write port.
// master = pipeline/BHT side, slave = the resolve unit.
interface or1k_branch_resolve_unit_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BHT_INDEX_WIDTH      = 6
);
  logic                            padv_decode_i;
  logic                            padv_execute_i;
  logic                            pipeline_flush_i;
  logic                            decode_op_bf_i;
  logic                            decode_op_bnf_i;
  logic                            decode_predicted_flag_i;
  logic [1:0]                      decode_bht_state_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_branch_target_i;
  logic                            execute_flag_i;
  logic                            branch_mispredict_o;
  logic [OPTION_OPERAND_WIDTH-1:0] branch_redirect_pc_o;
  logic                            bht_we_o;
  logic [BHT_INDEX_WIDTH-1:0]      bht_waddr_o;
  logic [1:0]                      bht_wdata_o;
  logic [31:0]                     branch_count_o;
  logic [31:0]                     mispredict_count_o;

  modport master (
    output padv_decode_i, padv_execute_i, pipeline_flush_i,
    output decode_op_bf_i, decode_op_bnf_i, decode_predicted_flag_i,
    output decode_bht_state_i, decode_pc_i, decode_branch_target_i, execute_flag_i,
    input  branch_mispredict_o, branch_redirect_pc_o,
    input  bht_we_o, bht_waddr_o, bht_wdata_o,
    input  branch_count_o, mispredict_count_o
  );

  modport slave (
    input  padv_decode_i, padv_execute_i, pipeline_flush_i,
    input  decode_op_bf_i, decode_op_bnf_i, decode_predicted_flag_i,
    input  decode_bht_state_i, decode_pc_i, decode_branch_target_i, execute_flag_i,
    output branch_mispredict_o, branch_redirect_pc_o,
    output bht_we_o, bht_waddr_o, bht_wdata_o,
    output branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/or1k_branch_resolve_unit.sv
// Resolves l.bf/l.bnf predictions at execute, redirects on mispredict, writes BHT (stats: OR1K_BRANCH_STATS_EN).
// Latency: results registered one cycle after the resolving padv_execute edge.
// Backpressure: none; follows padv_decode/padv_execute, flush discards pending and same-cycle work.
module or1k_branch_resolve_unit #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BHT_INDEX_WIDTH      = 6
) (
  input logic clk,
  input logic rst,
  or1k_branch_resolve_unit_if.slave bru
);
  typedef enum logic {IDLE, PEND} state_t;

  state_t                          state_q, state_d;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_q, target_q;
  logic                            op_bf_q, pred_q;
  logic [1:0]                      bht_state_q;

  logic                            mispredict_q, we_q;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_q;
  logic [BHT_INDEX_WIDTH-1:0]      waddr_q;
  logic [1:0]                      wdata_q;

  logic                            dec_branch, capture, resolve;
  logic                            actual_taken, mispredict_d;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_d;
  logic [1:0]                      cnt_next;

  always_comb begin
    dec_branch   = bru.padv_decode_i & (bru.decode_op_bf_i | bru.decode_op_bnf_i);
    resolve      = !bru.pipeline_flush_i && state_q == PEND && bru.padv_execute_i;
    // A new branch can only enter while the slot is free or being vacated this cycle.
    capture      = !bru.pipeline_flush_i && dec_branch && (state_q == IDLE || bru.padv_execute_i);
    actual_taken = op_bf_q ? bru.execute_flag_i : !bru.execute_flag_i;
    mispredict_d = actual_taken != pred_q;
    redirect_d   = actual_taken ? target_q : pc_q + OPTION_OPERAND_WIDTH'(8);
    if (actual_taken)
      cnt_next = (bht_state_q == 2'd3) ? 2'd3 : bht_state_q + 2'd1;
    else
      cnt_next = (bht_state_q == 2'd0) ? 2'd0 : bht_state_q - 2'd1;

    state_d = state_q;
    if (bru.pipeline_flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (dec_branch) state_d = PEND;
        PEND:    if (bru.padv_execute_i) state_d = dec_branch ? PEND : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      target_q     <= '0;
      op_bf_q      <= 1'b0;
      pred_q       <= 1'b0;
      bht_state_q  <= 2'd0;
      mispredict_q <= 1'b0;
      we_q         <= 1'b0;
      redirect_q   <= '0;
      waddr_q      <= '0;
      wdata_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      mispredict_q <= resolve & mispredict_d;
      we_q         <= resolve;
      if (capture) begin
        pc_q        <= bru.decode_pc_i;
        target_q    <= bru.decode_branch_target_i;
        op_bf_q     <= bru.decode_op_bf_i;
        pred_q      <= bru.decode_predicted_flag_i;
        bht_state_q <= bru.decode_bht_state_i;
      end
      if (resolve) begin
        redirect_q <= redirect_d;
        waddr_q    <= pc_q[BHT_INDEX_WIDTH+1:2];
        wdata_q    <= cnt_next;
      end
    end
  end

  assign bru.branch_mispredict_o  = mispredict_q;
  assign bru.branch_redirect_pc_o = redirect_q;
  assign bru.bht_we_o             = we_q;
  assign bru.bht_waddr_o          = waddr_q;
  assign bru.bht_wdata_o          = wdata_q;

`ifdef OR1K_BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else if (resolve) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_d) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign bru.branch_count_o     = branch_cnt_q;
  assign bru.mispredict_count_o = mispredict_cnt_q;
`else
  assign bru.branch_count_o     = 32'd0;
  assign bru.mispredict_count_o = 32'd0;
`endif
endmodule
